// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle SLL/SRL/SRA unit that shifts by up to STEP
// bit positions per clock. It takes requests over a Start/Ready handshake and
// returns results over a Valid/ResultReady handshake. Busy stalls the
// execute stage while the operand is being shifted.
module iterative_shifter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int STEP          = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Start,
  output logic                          Ready,
  input  logic [DATA_WIDTH-1:0]         SrcA,
  input  logic [$clog2(DATA_WIDTH)-1:0] Shamt,
  input  logic [OPCODE_LENGTH-1:0]      Operation,
  output logic                          Busy,
  output logic                          Valid,
  input  logic                          ResultReady,
  output logic [DATA_WIDTH-1:0]         Rd,
  output logic                          IllegalOp
);

  localparam int SW = $clog2(DATA_WIDTH);

  // The remaining count never exceeds DATA_WIDTH-1, so a STEP larger than
  // that behaves like DATA_WIDTH-1 and still fits in the remaining-count width.
  localparam int            STEP_CLAMP = (STEP > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : STEP;
  localparam logic [SW-1:0] STEP_V     = SW'(STEP_CLAMP);

  // Opcodes shared with the ALU.
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1011);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    acc_q;
  logic [SW-1:0]            rem_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic                     illegal_q;

  logic                     accept;
  logic                     op_legal;
  logic [SW-1:0]            step_amt;
  logic [DATA_WIDTH-1:0]    acc_shifted;

  assign accept   = Start && (state_q == IDLE);
  assign op_legal = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign step_amt = (rem_q > STEP_V) ? STEP_V : rem_q;

  // One shift step of the accumulator, by min(remaining, STEP) positions.
  // NOTE: every output of an always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_shifted = acc_q;
    case (op_q)
      OP_SLL:  acc_shifted = acc_q << step_amt;
      OP_SRL:  acc_shifted = acc_q >> step_amt;
      // An arithmetic shift keeps the MSB in place, so the sign captured at
      // accept keeps filling from the top on every step.
      OP_SRA:  acc_shifted = $signed(acc_q) >>> step_amt;
      default: acc_shifted = acc_q;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge, in whatever order the
  // blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ((Shamt == '0) || !op_legal) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (rem_q == step_amt) state_d = DONE;
      end
      DONE: begin
        if (ResultReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state, so they are one-hot.
  always_comb begin
    Ready = 1'b0;
    Busy  = 1'b0;
    Valid = 1'b0;
    case (state_q)
      IDLE:    Ready = 1'b1;
      SHIFT:   Busy  = 1'b1;
      DONE:    Valid = 1'b1;
      default: Ready = 1'b0;
    endcase
  end

  // Datapath: capture the operands on accept and step the accumulator in SHIFT.
  // NOTE: the datapath registers are reset as well, because Rd and IllegalOp
  // must read as zero straight after reset, not only after the first accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      rem_q     <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            acc_q     <= SrcA;
            rem_q     <= Shamt;
            op_q      <= Operation;
            illegal_q <= !op_legal;
          end
        end
        SHIFT: begin
          acc_q <= acc_shifted;
          rem_q <= rem_q - step_amt;
        end
        default: begin
          acc_q <= acc_q;
        end
      endcase
    end
  end

  assign Rd        = acc_q;
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter: randomized and directed scoreboard bench for
// iterative_shifter. Five instances cover STEP = 1, 3, 4, 8 and 32. Only the
// selected instance is started at a time, and a monitor checks its results
// against a reference model.
module tb_iterative_shifter;

  localparam int NI = 5;
  localparam logic [3:0] SLL = 4'b0100;
  localparam logic [3:0] SRL = 4'b0101;
  localparam logic [3:0] SRA = 4'b1011;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] ready_v, busy_v, valid_v, ill_v;
  logic [31:0]   rd_a [NI];
  logic [31:0]   srca = '0;
  logic [4:0]    shamt = '0;
  logic [3:0]    oper = '0;
  logic          rr = 1'b0;

  int sel = 0;
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
    int          n;
    int          k;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : (g == 3) ? 8 : 32;
    iterative_shifter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .STEP(ST)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .Start      (start_v[g]),
      .Ready      (ready_v[g]),
      .SrcA       (srca),
      .Shamt      (shamt),
      .Operation  (oper),
      .Busy       (busy_v[g]),
      .Valid      (valid_v[g]),
      .ResultReady(rr),
      .Rd         (rd_a[g]),
      .IllegalOp  (ill_v[g])
    );
  end

  function automatic int step_of(int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      3:       return 8;
      default: return 32;
    endcase
  endfunction

  // Reference model: plain shift semantics of the ALU.
  function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] sh, logic [3:0] op);
    logic signed [31:0] s;
    s = a;
    case (op)
      SLL:     return a << sh;
      SRL:     return a >> sh;
      SRA:     return s >>> sh;
      default: return a;
    endcase
  endfunction

  function automatic logic is_illegal(logic [3:0] op);
    return !(op == SLL || op == SRL || op == SRA);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: protocol invariants every cycle, and a scoreboard pop each time
  // the selected instance raises Valid.
  initial begin : monitor
    logic pv;
    logic oh;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv       = 1'b0;
        busy_cnt = 0;
      end else begin
        oh = 1'b1;
        for (int g = 0; g < NI; g++)
          if ($countones({ready_v[g], busy_v[g], valid_v[g]}) != 1) oh = 1'b0;
        check("onehot", 32'(oh), 32'd1);
        if (busy_v[sel]) busy_cnt++;
        if (valid_v[sel] && !pv) begin
          if (sb.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rd", rd_a[sel], e.rd);
            check("illegal", 32'(ill_v[sel]), 32'(e.ill));
            check("latency", 32'(cyc - e.k), 32'(e.n));
            check("busy_cycles", 32'(busy_cnt), 32'(e.n));
          end
          busy_cnt = 0;
        end
        pv = valid_v[sel];
      end
    end
  end

  // Issue one request to the selected instance and push its expected result.
  task automatic issue(logic [31:0] a, logic [4:0] sh, logic [3:0] op);
    exp_t e;
    int t;
    t = 0;
    while (!ready_v[sel] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_v[sel]) check("ready_timeout", 32'd0, 32'd1);
    srca  = a;
    shamt = sh;
    oper  = op;
    start_v[sel] = 1'b1;
    e.rd  = ref_shift(a, sh, op);
    e.ill = is_illegal(op);
    e.n   = e.ill ? 0 : (int'(sh) + step_of(sel) - 1) / step_of(sel);
    e.k   = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start_v = '0;
    // Later input changes must not affect the transaction in flight.
    srca  = $urandom;
    shamt = 5'($urandom);
    oper  = 4'($urandom);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!valid_v[sel] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!valid_v[sel]) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Full transaction; hold = cycles of backpressure in DONE (0 = ResultReady high throughout).
  task automatic do_txn(int s, logic [31:0] a, logic [4:0] sh, logic [3:0] op, int hold);
    sel = s;
    rr  = (hold == 0);
    issue(a, sh, op);
    wait_valid();
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      rr = 1'b1;
    end
    @(negedge clk);
    rr = 1'b0;
    check("return_idle", 32'({ready_v[sel], valid_v[sel]}), 32'b10);
  endtask

  initial begin : stim
    logic [31:0] exp_rd;
    logic [3:0]  op;
    int          steps [4];
    steps = '{0, 1, 3, 4};  // instance indices for STEP 1, 3, 8, 32

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_rd", rd_a[0], 32'h0);
    check("rst_ill", 32'(ill_v[0]), 32'd0);
    check("rst_hs", 32'({ready_v[0], busy_v[0], valid_v[0]}), 32'b100);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of a long SRA.
    sel = 0;
    issue(32'h8000_0000, 5'd31, SRA);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_rd", rd_a[0], 32'h0);
    check("midrst_hs", 32'({ready_v[0], busy_v[0], valid_v[0]}), 32'b100);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_novalid", 32'(valid_v[0]), 32'd0);

    // Directed cases.
    do_txn(0, 32'h0000_0001, 5'd31, SLL, 0);
    check("sll31", rd_a[0], 32'h8000_0000);
    do_txn(2, 32'hF000_0000, 5'd4, SRA, 0);
    check("sra4", rd_a[2], 32'hFF00_0000);
    do_txn(2, 32'hF000_0000, 5'd4, SRL, 1);
    check("srl4", rd_a[2], 32'h0F00_0000);
    do_txn(0, 32'h1234_5678, 5'd0, SLL, 0);
    check("shamt0", rd_a[0], 32'h1234_5678);
    do_txn(0, 32'hDEAD_BEEF, 5'd5, 4'b0000, 0);
    check("illegal_rd", rd_a[0], 32'hDEAD_BEEF);
    check("illegal_flag", 32'(ill_v[0]), 32'd1);

    // Backpressure with Start pulsed during DONE.
    sel = 1;
    rr  = 1'b0;
    exp_rd = ref_shift(32'hA5C3_0F96, 5'd7, SRL);
    issue(32'hA5C3_0F96, 5'd7, SRL);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        srca  = 32'h1111_1111;
        shamt = 5'd2;
        oper  = SLL;
        start_v[sel] = 1'b1;
      end else begin
        start_v = '0;
      end
      @(negedge clk);
      check("bp_valid", 32'(valid_v[sel]), 32'd1);
      check("bp_rd", rd_a[sel], exp_rd);
    end
    start_v = '0;
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    check("bp_idle", 32'({ready_v[sel], valid_v[sel]}), 32'b10);
    repeat (10) @(negedge clk);
    check("bp_no_queue", 32'({ready_v[sel], busy_v[sel], valid_v[sel]}), 32'b100);

    // Random regression across STEP = 1, 3, 8, 32.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 25; i++) begin
        case ($urandom_range(0, 3))
          0:       op = SLL;
          1:       op = SRL;
          2:       op = SRA;
          default: op = 4'($urandom);
        endcase
        do_txn(steps[s], $urandom, 5'($urandom), op, $urandom_range(0, 3));
      end
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
